decode_issue: RTL and testbench

- Decode/issue stage that consumes the fetch stage's PC/IR/valid outputs and produces the fetch-side stall signals (`O_DepStallSignal`, `O_BranchStallSignal`).
- Tracks in-flight register writes with a scoreboard and holds a branch shadow until the memory stage resolves the branch.
- Issues decoded, registered fields to execute.
- Sits between fetch and execute; all state updates on negedge `I_CLOCK`, the same edge as fetch.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/decode_issue_if.sv | 39 +++
 rtl/reg_scoreboard.sv | 44 ++++
 rtl/decode_issue.sv | 113 +++++++++++
 tb/tb_decode_issue.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: IR field positions, opcode classes and the class decoder.
package decode_pkg;

  typedef enum logic [2:0] {
    ALU_R,
    ALU_I,
    LOAD,
    STORE,
    BRANCH,
    BUBBLE
  } opc_class_e;

  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 24;
  localparam int unsigned DST_HI  = 23;
  localparam int unsigned DST_LO  = 20;
  localparam int unsigned SRC1_HI = 19;
  localparam int unsigned SRC1_LO = 16;
  localparam int unsigned SRC2_HI = 15;
  localparam int unsigned SRC2_LO = 12;
  localparam int unsigned IMM_HI  = 15;
  localparam int unsigned IMM_LO  = 0;

  localparam logic [7:0] OPC_BUBBLE = 8'hFF;

  // Class is selected by the upper opcode nibble; anything unassigned is a bubble.
  function automatic opc_class_e opc_class(input logic [7:0] opcode);
    opc_class_e c;
    case (opcode[7:4])
      4'h0:    c = ALU_R;
      4'h1:    c = ALU_I;
      4'h2:    c = LOAD;
      4'h3:    c = STORE;
      4'h4:    c = BRANCH;
      default: c = BUBBLE;
    endcase
    return c;
  endfunction

  function automatic logic writes_dst(input opc_class_e c);
    return (c == ALU_R) || (c == ALU_I) || (c == LOAD);
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch-side / execute-side signal bundle of the decode/issue stage.
interface decode_issue_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned IR_W   = 32,
  parameter int unsigned RIDX_W = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              I_LOCK;
  logic [PC_W-1:0]   I_PC;
  logic [IR_W-1:0]   I_IR;
  logic              I_FE_Valid;
  logic              I_BranchAddrSelect;
  logic              I_WB_Valid;
  logic [RIDX_W-1:0] I_WB_DestReg;

  logic              O_LOCK;
  logic              O_DepStallSignal;
  logic              O_BranchStallSignal;
  logic              O_DE_Valid;
  logic [PC_W-1:0]   O_PC;
  logic [7:0]        O_Opcode;
  logic [RIDX_W-1:0] O_DestReg;
  logic [RIDX_W-1:0] O_Src1Reg;
  logic [RIDX_W-1:0] O_Src2Reg;
  logic [15:0]       O_Imm16;
  logic [CNT_W-1:0]  O_DepStallCount;

  modport master (
    output I_LOCK, I_PC, I_IR, I_FE_Valid, I_BranchAddrSelect, I_WB_Valid, I_WB_DestReg,
    input  O_LOCK, O_DepStallSignal, O_BranchStallSignal, O_DE_Valid, O_PC, O_Opcode,
           O_DestReg, O_Src1Reg, O_Src2Reg, O_Imm16, O_DepStallCount
  );

  modport slave (
    input  I_LOCK, I_PC, I_IR, I_FE_Valid, I_BranchAddrSelect, I_WB_Valid, I_WB_DestReg,
    output O_LOCK, O_DepStallSignal, O_BranchStallSignal, O_DE_Valid, O_PC, O_Opcode,
           O_DestReg, O_Src1Reg, O_Src2Reg, O_Imm16, O_DepStallCount
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard with same-cycle writeback bypass on the hazard check.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned RIDX_W   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_set_valid,
  input  logic [RIDX_W-1:0]      i_set_idx,
  input  logic                   i_clr_valid,
  input  logic [RIDX_W-1:0]      i_clr_idx,
  input  logic [2:0][RIDX_W-1:0] i_rd_idx,
  input  logic [2:0]             i_rd_en,
  output logic                   o_hazard,
  output logic [NUM_REGS-1:0]    o_busy
);

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_eff_busy;

  assign w_clr_mask = i_clr_valid ? (ONE << i_clr_idx) : '0;
  assign w_set_mask = i_set_valid ? (ONE << i_set_idx) : '0;
  assign w_eff_busy = r_busy & ~w_clr_mask;
  assign o_busy     = r_busy;

  // Any enabled read port hitting an effectively-busy register is a hazard.
  always_comb begin
    o_hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i_rd_en[i] && w_eff_busy[i_rd_idx[i]]) o_hazard = 1'b1;
    end
  end

  // Clear first, then set, so a same-edge set on the cleared register wins.
  always_ff @(negedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_eff_busy | w_set_mask;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: hazard detection, branch shadow and registered issue to execute.
module decode_issue
  import decode_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned IR_W     = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned RIDX_W   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic           I_CLOCK,
  input logic           I_RESET,
  decode_issue_if.slave bus
);

  logic [IR_W-1:0]      w_ir;
  logic [7:0]           w_opcode;
  logic [RIDX_W-1:0]    w_dst, w_src1, w_src2;
  opc_class_e           w_class;
  logic                 w_writes;
  logic [2:0]           w_rd_en;
  logic                 w_hazard, w_cand, w_issue, w_dep_stall, w_set_valid, w_clr_valid;
  logic [NUM_REGS-1:0]  w_busy;

  logic                 r_lock, r_br_pend, r_de_valid;
  logic [PC_W-1:0]      r_pc;
  logic [7:0]           r_opcode;
  logic [RIDX_W-1:0]    r_dst, r_src1, r_src2;
  logic [15:0]          r_imm;
  logic [CNT_W-1:0]     r_cnt;

  assign w_ir     = bus.I_IR;
  assign w_opcode = w_ir[OPC_HI:OPC_LO];
  assign w_dst    = w_ir[DST_HI:DST_LO];
  assign w_src1   = w_ir[SRC1_HI:SRC1_LO];
  assign w_src2   = w_ir[SRC2_HI:SRC2_LO];
  assign w_class  = opc_class(w_opcode);
  assign w_writes = writes_dst(w_class);

  // Port 2 checks dst: WAW for writers, data read for stores.
  assign w_rd_en = {w_writes || (w_class == STORE), w_class == ALU_R, w_class != BUBBLE};

  assign w_cand      = bus.I_LOCK & bus.I_FE_Valid & ~I_RESET & ~r_br_pend & (w_class != BUBBLE);
  assign w_dep_stall = w_cand & w_hazard;
  assign w_issue     = w_cand & ~w_hazard;
  assign w_set_valid = w_issue & w_writes;
  assign w_clr_valid = bus.I_WB_Valid & bus.I_LOCK;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .RIDX_W   (RIDX_W)
  ) u_sb (
    .i_clk       (I_CLOCK),
    .i_rst       (I_RESET),
    .i_set_valid (w_set_valid),
    .i_set_idx   (w_dst),
    .i_clr_valid (w_clr_valid),
    .i_clr_idx   (bus.I_WB_DestReg),
    .i_rd_idx    ({w_dst, w_src2, w_src1}),
    .i_rd_en     (w_rd_en),
    .o_hazard    (w_hazard),
    .o_busy      (w_busy)
  );

  // A writer must never issue onto a register that stays busy after the bypassed clear.
  assert property (@(negedge I_CLOCK) disable iff (I_RESET)
    w_set_valid |-> !(w_busy[w_dst] && !(bus.I_WB_Valid && bus.I_WB_DestReg == w_dst)));

  assign bus.O_DepStallSignal    = w_dep_stall;
  assign bus.O_BranchStallSignal = r_br_pend | (w_issue & (w_class == BRANCH));
  assign bus.O_LOCK              = r_lock;
  assign bus.O_DE_Valid          = r_de_valid;
  assign bus.O_PC                = r_pc;
  assign bus.O_Opcode            = r_opcode;
  assign bus.O_DestReg           = r_dst;
  assign bus.O_Src1Reg           = r_src1;
  assign bus.O_Src2Reg           = r_src2;
  assign bus.O_Imm16             = r_imm;
  assign bus.O_DepStallCount     = r_cnt;

  // Issue register, branch shadow and stall counter; reset, then lock-hold, then normal.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      r_lock     <= 1'b0;
      r_br_pend  <= 1'b0;
      r_de_valid <= 1'b0;
      r_pc       <= '0;
      r_opcode   <= OPC_BUBBLE;
      r_dst      <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_imm      <= '0;
      r_cnt      <= '0;
    end else if (!bus.I_LOCK) begin
      r_lock     <= 1'b0;
      r_de_valid <= 1'b0;
      r_opcode   <= OPC_BUBBLE;
    end else begin
      r_lock     <= 1'b1;
      r_de_valid <= w_issue;
      r_pc       <= bus.I_PC;
      r_opcode   <= w_issue ? w_opcode : OPC_BUBBLE;
      r_dst      <= w_dst;
      r_src1     <= w_src1;
      r_src2     <= w_src2;
      r_imm      <= w_ir[IMM_HI:IMM_LO];
      if (w_issue && (w_class == BRANCH)) r_br_pend <= 1'b1;
      else if (bus.I_BranchAddrSelect)    r_br_pend <= 1'b0;
      if (w_dep_stall && (r_cnt != '1))   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: per-cycle stall checks plus an issue scoreboard.
module tb_decode_issue;
  import decode_pkg::*;

  localparam int unsigned CntW = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] ir;
  } exp_t;

  logic r_clk = 1'b0;
  logic r_rst = 1'b1;
  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 r_clk = ~r_clk;

  decode_issue_if #(.PC_W(16), .IR_W(32), .RIDX_W(4), .CNT_W(CntW)) bus ();

  decode_issue #(
    .PC_W     (16),
    .IR_W     (32),
    .NUM_REGS (16),
    .RIDX_W   (4),
    .CNT_W    (CntW)
  ) u_dut (
    .I_CLOCK (r_clk),
    .I_RESET (r_rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [11:0] lo);
    return {op, d, s1, s2, lo};
  endfunction

  // One clock: drive, check combinational stalls before the edge, check issue after it.
  task automatic step(input logic rst, input logic lock, input logic fv,
                      input logic [15:0] pc, input logic [31:0] ir,
                      input logic bas, input logic wbv, input logic [3:0] wbd,
                      input logic e_dep, input logic e_br, input logic e_iss);
    exp_t e;
    r_rst                  = rst;
    bus.I_LOCK             = lock;
    bus.I_FE_Valid         = fv;
    bus.I_PC               = pc;
    bus.I_IR               = ir;
    bus.I_BranchAddrSelect = bas;
    bus.I_WB_Valid         = wbv;
    bus.I_WB_DestReg       = wbd;
    if (e_iss) q_exp.push_back('{pc: pc, ir: ir});
    #2;
    check("dep_stall", {31'd0, bus.O_DepStallSignal}, {31'd0, e_dep});
    check("br_stall", {31'd0, bus.O_BranchStallSignal}, {31'd0, e_br});
    @(negedge r_clk);
    #1;
    check("de_valid", {31'd0, bus.O_DE_Valid}, {31'd0, e_iss});
    check("lock_out", {31'd0, bus.O_LOCK}, {31'd0, lock & ~rst});
    if (bus.O_DE_Valid) begin
      if (q_exp.size() == 0) begin
        check("unexp_issue", {31'd0, bus.O_DE_Valid}, 32'd0);
      end else begin
        e = q_exp.pop_front();
        check("iss_pc", {16'd0, bus.O_PC}, {16'd0, e.pc});
        check("iss_opc", {24'd0, bus.O_Opcode}, {24'd0, e.ir[31:24]});
        check("iss_dst", {28'd0, bus.O_DestReg}, {28'd0, e.ir[23:20]});
        check("iss_src1", {28'd0, bus.O_Src1Reg}, {28'd0, e.ir[19:16]});
        check("iss_src2", {28'd0, bus.O_Src2Reg}, {28'd0, e.ir[15:12]});
        check("iss_imm", {16'd0, bus.O_Imm16}, {16'd0, e.ir[15:0]});
      end
    end else begin
      check("bubble_opc", {24'd0, bus.O_Opcode}, 32'h0000_00FF);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.I_LOCK = 1'b0; bus.I_FE_Valid = 1'b0; bus.I_PC = '0; bus.I_IR = '0;
    bus.I_BranchAddrSelect = 1'b0; bus.I_WB_Valid = 1'b0; bus.I_WB_DestReg = '0;
    @(negedge r_clk);
    #1;
    do_reset();
    check("rst_cnt", {28'd0, bus.O_DepStallCount}, 32'd0);
    check("rst_pc", {16'd0, bus.O_PC}, 32'd0);

    // Reset mid-stream clears the scoreboard entry for R3.
    step(0, 1, 1, 16'h0010, mk(8'h01, 4'd3, 4'd1, 4'd2, 12'h5A5), 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 16'h0011, mk(8'h02, 4'd4, 4'd3, 4'd0, 12'h111), 0, 0, 0, 0, 0, 0);
    check("rst2_cnt", {28'd0, bus.O_DepStallCount}, 32'd0);
    check("rst2_pc", {16'd0, bus.O_PC}, 32'd0);
    step(0, 1, 1, 16'h0011, mk(8'h02, 4'd4, 4'd3, 4'd0, 12'h111), 0, 0, 0, 0, 0, 1);

    // RAW: three stall cycles, consumer issues on the WB edge via bypass.
    do_reset();
    step(0, 1, 1, 16'h0020, mk(8'h01, 4'd2, 4'd0, 4'd1, 12'h0C3), 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      step(0, 1, 1, 16'h0021, mk(8'h02, 4'd6, 4'd2, 4'd0, 12'h777), 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 16'h0021, mk(8'h02, 4'd6, 4'd2, 4'd0, 12'h777), 0, 1, 4'd2, 0, 0, 1);
    check("raw_cnt", {28'd0, bus.O_DepStallCount}, 32'd3);

    // WAW with same-edge clear and set of R5: R5 must remain busy.
    do_reset();
    step(0, 1, 1, 16'h0030, mk(8'h10, 4'd5, 4'd1, 4'd0, 12'h234), 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 16'h0031, mk(8'h11, 4'd5, 4'd1, 4'd0, 12'h456), 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 16'h0031, mk(8'h11, 4'd5, 4'd1, 4'd0, 12'h456), 0, 1, 4'd5, 0, 0, 1);
    step(0, 1, 1, 16'h0032, mk(8'h02, 4'd7, 4'd5, 4'd0, 12'h000), 0, 0, 0, 1, 0, 0);

    // Branch shadow: two dropped instructions, resolve on the third cycle.
    do_reset();
    step(0, 1, 1, 16'h0040, mk(8'h40, 4'd0, 4'd0, 4'd0, 12'h080), 0, 0, 0, 0, 1, 1);
    step(0, 1, 1, 16'h0041, mk(8'h01, 4'd1, 4'd2, 4'd3, 12'h001), 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 16'h0042, mk(8'h01, 4'd2, 4'd2, 4'd3, 12'h002), 1, 0, 0, 0, 1, 0);
    step(0, 1, 1, 16'h0043, mk(8'h01, 4'd3, 4'd0, 4'd0, 12'h003), 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 16'h0044, mk(8'h02, 4'd8, 4'd1, 4'd2, 12'h004), 0, 0, 0, 0, 0, 1);

    // Lock low and bubble opcodes: nothing issues and the scoreboard is untouched.
    do_reset();
    step(0, 0, 1, 16'h0050, mk(8'h01, 4'd9, 4'd0, 4'd0, 12'h005), 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 16'h0051, mk(8'hFF, 4'd9, 4'd0, 4'd0, 12'h006), 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 16'h0052, mk(8'h7A, 4'd10, 4'd0, 4'd0, 12'h007), 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 16'h0053, mk(8'h02, 4'd11, 4'd9, 4'd10, 12'h008), 0, 0, 0, 0, 0, 1);

    // Counter saturation at 2^CntW - 1.
    do_reset();
    step(0, 1, 1, 16'h0060, mk(8'h01, 4'd12, 4'd0, 4'd0, 12'h009), 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 1, 16'h0061, mk(8'h02, 4'd13, 4'd12, 4'd0, 12'h00A), 0, 0, 0, 1, 0, 0);
      check("sat_cnt", {28'd0, bus.O_DepStallCount}, (k < 15) ? k : 15);
    end
    step(0, 1, 1, 16'h0061, mk(8'h02, 4'd13, 4'd12, 4'd0, 12'h00A), 0, 1, 4'd12, 0, 0, 1);
    check("sat_hold", {28'd0, bus.O_DepStallCount}, 32'd15);

    check("q_empty", q_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
